sram_address_manager: RTL

- Sequences the two-chip SRAM packet store in front of memory_controller.
- Owns the circular write and read pointers ({chip, address}) that feed memory_controller's WRITE_ADDRESS/WRITE_CHIP_SELECT and READ_ADDRESS/READ_CHIP_SELECT inputs, and advances them on its NEXT_WRITE/NEXT_READ pulses.
- Turns downlink read requests into single READ_CMD pulses, tracks fill level, and applies the overflow policy when both chips are full.

---
 rtl/sram_address_manager.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_address_manager.sv
// Circular write/read pointer manager for the two-chip SRAM packet store.
// It issues single read commands, tracks fill level and applies the overflow policy.
`timescale 1ns/1ps
module sram_address_manager #(
  parameter int ADDR_WIDTH       = 18,
  parameter int STEP             = 5,
  parameter int PKTS_PER_CHIP    = 52428,
  parameter int CNT_WIDTH        = 17,
  parameter int OVERWRITE_OLDEST = 0,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                  CLK_48MHZ,
  input  logic                  RESET,
  input  logic                  NEXT_WRITE,
  input  logic                  NEXT_READ,
  input  logic                  READ_REQ,
  output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  output logic                  WRITE_CHIP_SELECT,
  output logic [ADDR_WIDTH-1:0] READ_ADDRESS,
  output logic                  READ_CHIP_SELECT,
  output logic                  READ_CMD,
  output logic                  READ_BUSY,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [CNT_WIDTH-1:0]  FILL_COUNT,
  output logic                  OVERFLOW,
  output logic                  READ_TIMEOUT
);

  typedef struct packed {
    logic                  chip;
    logic [ADDR_WIDTH-1:0] addr;
  } ptr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((PKTS_PER_CHIP - 1) * STEP);
  localparam logic [ADDR_WIDTH-1:0] STEP_W    = ADDR_WIDTH'(STEP);
  localparam logic [CNT_WIDTH-1:0]  CAPACITY  = CNT_WIDTH'(2 * PKTS_PER_CHIP);
  localparam int                    TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         T_LAST    = TW'(TIMEOUT_CYCLES - 1);

  ptr_t                 wr_ptr;
  ptr_t                 rd_ptr;
  state_t               state;
  logic                 pending;
  logic                 read_cmd;
  logic                 read_busy;
  logic [CNT_WIDTH-1:0] fill_count;
  logic                 overflow;
  logic                 read_timeout;
  logic [TW-1:0]        tcnt;

  logic rd_accept;
  logic wr_adv;
  logic rd_adv;
  logic cnt_inc;
  logic cnt_dec;
  logic lost;

  // The last slot of a chip hands over to address 0 of the other chip.
  function automatic ptr_t advance(input ptr_t p);
    ptr_t n;
    if (p.addr == LAST_ADDR) begin
      n.addr = '0;
      n.chip = ~p.chip;
    end else begin
      n.addr = p.addr + STEP_W;
      n.chip = p.chip;
    end
    return n;
  endfunction

  assign rd_accept = NEXT_READ && (state == WAIT);

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_adv  = 1'b0;
    rd_adv  = rd_accept;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    lost    = 1'b0;
    if (NEXT_WRITE && rd_accept) begin
      wr_adv = 1'b1;
    end else if (NEXT_WRITE && (fill_count != CAPACITY)) begin
      wr_adv  = 1'b1;
      cnt_inc = 1'b1;
    end else if (NEXT_WRITE) begin
      lost = 1'b1;
      // Overwriting the oldest is only safe while no read targets that slot.
      if ((OVERWRITE_OLDEST != 0) && (state == IDLE)) begin
        wr_adv = 1'b1;
        rd_adv = 1'b1;
      end
    end else if (rd_accept) begin
      cnt_dec = (fill_count != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      state        <= IDLE;
      pending      <= 1'b0;
      read_cmd     <= 1'b0;
      read_busy    <= 1'b0;
      fill_count   <= '0;
      overflow     <= 1'b0;
      read_timeout <= 1'b0;
      tcnt         <= '0;
    end else begin
      if (wr_adv) wr_ptr <= advance(wr_ptr);
      if (rd_adv) rd_ptr <= advance(rd_ptr);
      if (cnt_inc)      fill_count <= fill_count + CNT_WIDTH'(1);
      else if (cnt_dec) fill_count <= fill_count - CNT_WIDTH'(1);
      if (lost) overflow <= 1'b1;

      read_cmd <= 1'b0;
      case (state)
        IDLE: begin
          if ((pending || READ_REQ) && (fill_count != '0)) begin
            state     <= ISSUE;
            read_cmd  <= 1'b1;
            read_busy <= 1'b1;
          end else if (READ_REQ) begin
            pending <= 1'b1;
          end
        end
        ISSUE: begin
          // A request arriving during the command is kept for the next read.
          pending <= READ_REQ;
          tcnt    <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (READ_REQ) pending <= 1'b1;
          if (rd_accept) begin
            state     <= IDLE;
            read_busy <= 1'b0;
          end else if (tcnt == T_LAST) begin
            state        <= IDLE;
            read_busy    <= 1'b0;
            read_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          read_busy <= 1'b0;
        end
      endcase
    end
  end

  assign WRITE_ADDRESS     = wr_ptr.addr;
  assign WRITE_CHIP_SELECT = wr_ptr.chip;
  assign READ_ADDRESS      = rd_ptr.addr;
  assign READ_CHIP_SELECT  = rd_ptr.chip;
  assign READ_CMD          = read_cmd;
  assign READ_BUSY         = read_busy;
  assign FILL_COUNT        = fill_count;
  assign EMPTY             = (fill_count == '0);
  assign FULL              = (fill_count == CAPACITY);
  assign OVERFLOW          = overflow;
  assign READ_TIMEOUT      = read_timeout;

endmodule
